ifu_fetch_ctrl: RTL and testbench
=================================

Name: ifu_fetch_ctrl

Overview:
Sequences the instruction fetch loop around the PC generator. Issues one instruction-memory read per instruction over a valid/ready address/data handshake and holds the fetched instruction for the execute stage. Once execute reports completion, it produces a single-cycle pc_we strobe so the PC register advances to the next PC. It also handles memory error responses, response timeouts, and halt.

Parameters:
DW, 64, PC/address width
IW, 32, instruction width
TMO, 255, max cycles waiting for rvalid before fault (1..255)

Ports:
clk  in  1  clock
rstn  in  1  synchronous active-low reset
pc  in  DW  current PC from the PC register
imem_araddr  out  DW  fetch address
imem_arvalid  out  1  address valid
imem_arready  in  1  memory accepts address
imem_rdata  in  IW  read data
imem_rresp  in  2  read response; 0 = OKAY, nonzero = error
imem_rvalid  in  1  read data valid
imem_rready  out  1  controller ready for data
inst  out  IW  held instruction to decode/execute
inst_valid  out  1  inst is valid for execute
exu_done  in  1  execute finished current instruction (level, sampled in EXEC)
halt_req  in  1  stop fetching (ebreak/trap-to-sim)
pc_we  out  1  one-cycle enable for PC register update
fetch_fault  out  1  fault pending
fault_cause  out  2  1 = bus error, 2 = timeout, 3 = misaligned pc
fault_ack  in  1  clears fault
halted  out  1  controller stopped

Behaviour:
- Reset: all state changes on the posedge clk only; rstn low at a posedge forces state IDLE.
- Reset values: imem_arvalid=0, imem_rready=0, inst=0, inst_valid=0, pc_we=0, fetch_fault=0, fault_cause=0, halted=0, timeout counter=0.
- Reset applied mid-transaction abandons the transaction. Any rvalid arriving afterwards is ignored (rready=0).
- imem_araddr = pc combinationally, always.
- States: IDLE, AR, R, EXEC, UPD, FAULT, HALT.
- IDLE:
  - Enters AR on the first cycle after rstn deasserts, so the first arvalid appears 1 cycle after reset release.
  - If halt_req=1, goes to HALT instead.
- AR:
  - If pc[1:0] != 0: no arvalid is issued; go to FAULT with cause 3.
  - Otherwise arvalid=1, held stable (address unchanged) until arready.
  - On arvalid&arready: go to R; counter cleared.
- R:
  - rready=1. Counter increments each cycle rvalid=0.
  - On rvalid with rresp==0: latch inst=rdata, go to EXEC.
  - On rvalid with rresp!=0: go to FAULT with cause 1.
  - If counter reaches TMO with no rvalid: go to FAULT with cause 2.
  - If rvalid arrives on the same cycle the counter reaches TMO, rvalid wins.
- EXEC:
  - inst_valid=1, inst held stable.
  - On exu_done=1: go to UPD. exu_done outside EXEC is ignored.
- UPD:
  - pc_we=1 for exactly this one cycle.
  - Next state is HALT if halt_req=1, else AR. The PC register loads on this edge, so AR presents the new pc.
  - Fetch-to-fetch minimum period with zero-wait memory: 4 cycles (AR, R, EXEC, UPD).
- halt_req is sampled only in IDLE and UPD. The in-flight instruction always completes.
- HALT: halted=1; no further requests. Exits only by reset.
- FAULT:
  - fetch_fault=1, fault_cause held; pc_we is never asserted.
  - On fault_ack=1: fault_cause cleared, go to AR (retry at the same pc; the trap path rewrites the PC externally before ack).
  - fault_ack in other states is ignored.
- Invariants:
  - pc_we and inst_valid are never high simultaneously.
  - arvalid is never deasserted before arready.
  - At most one outstanding read.

Test Plan:
- Reset release, PC register = 0x80000000, zero-wait memory returning 0x00000013 (nop), exu_done immediate → arvalid at cycle 1 with araddr 0x80000000; inst_valid in cycle 3; pc_we in cycle 4; next arvalid at araddr 0x80000004 in cycle 5.
- arready delayed 3 cycles, rvalid delayed 5 cycles → arvalid and araddr stable throughout AR; exactly one pc_we per instruction; no duplicate request.
- rvalid with rresp=2 → fetch_fault=1, fault_cause=1, no pc_we. fault_ack → arvalid reissued to the same address.
- rvalid never returned, TMO=255 → fault_cause=2 exactly 255 cycles after the handshake. Also check rvalid on the TMO cycle → normal EXEC, no fault.
- pc = 0x80000002 → cause 3 with imem_arvalid never asserted.
- halt_req raised during EXEC → instruction completes, pc_we pulses once, then halted=1, no further arvalid. rstn low for 1 cycle mid-R → all outputs at reset values next cycle, fetch restarts.

Source files
------------

// File: rtl/ifu_fetch_ctrl.sv
// ifu_fetch_ctrl: instruction fetch sequencer between the PC register, instruction memory and execute
// Ports:
//   clk, rstn                         clock, synchronous active-low reset
//   pc                                current PC; driven straight out as imem_araddr
//   imem_ar*/imem_r*                  single-outstanding valid/ready read channel to instruction memory
//   inst, inst_valid                  held instruction for execute, valid while waiting for exu_done
//   exu_done                          execute finished (only looked at while inst_valid)
//   halt_req                          stop fetching (looked at on leaving reset and on each PC update)
//   pc_we                             one-cycle PC register load strobe
//   fetch_fault, fault_cause, fault_ack   fault report (1 bus error, 2 timeout, 3 misaligned) and clear
//   halted                            controller stopped until reset
module ifu_fetch_ctrl #(
    parameter int DW  = 64,
    parameter int IW  = 32,
    parameter int TMO = 255
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic [DW-1:0] pc,
    output logic [DW-1:0] imem_araddr,
    output logic          imem_arvalid,
    input  logic          imem_arready,
    input  logic [IW-1:0] imem_rdata,
    input  logic [1:0]    imem_rresp,
    input  logic          imem_rvalid,
    output logic          imem_rready,
    output logic [IW-1:0] inst,
    output logic          inst_valid,
    input  logic          exu_done,
    input  logic          halt_req,
    output logic          pc_we,
    output logic          fetch_fault,
    output logic [1:0]    fault_cause,
    input  logic          fault_ack,
    output logic          halted
);
    typedef enum logic [2:0] {IDLE, AR, R, EXEC, UPD, FAULT, HALT} state_t;

    localparam logic [7:0] TMO_W = TMO[7:0];

    state_t        state, state_nx;
    logic [7:0]    cnt, cnt_nx;
    logic [IW-1:0] inst_nx;
    logic [1:0]    cause_nx;

    assign imem_araddr = pc;

    always_comb begin
        state_nx     = state;
        cnt_nx       = cnt;
        inst_nx      = inst;
        cause_nx     = fault_cause;
        imem_arvalid = 1'b0;
        imem_rready  = 1'b0;
        inst_valid   = 1'b0;
        pc_we        = 1'b0;
        fetch_fault  = 1'b0;
        halted       = 1'b0;
        case (state)
            IDLE: state_nx = halt_req ? HALT : AR;
            AR: begin
                // a misaligned pc never reaches the bus
                if (pc[1:0] != 2'b00) begin
                    state_nx = FAULT;
                    cause_nx = 2'd3;
                end else begin
                    imem_arvalid = 1'b1;
                    if (imem_arready) begin
                        state_nx = R;
                        cnt_nx   = '0;
                    end
                end
            end
            R: begin
                imem_rready = 1'b1;
                if (imem_rvalid) begin
                    if (imem_rresp == 2'b00) begin
                        inst_nx  = imem_rdata;
                        state_nx = EXEC;
                    end else begin
                        state_nx = FAULT;
                        cause_nx = 2'd1;
                    end
                end else begin
                    // cnt counts empty R cycles; rvalid on the TMO-th one still wins above
                    cnt_nx = cnt + 8'd1;
                    if (cnt_nx == TMO_W) begin
                        state_nx = FAULT;
                        cause_nx = 2'd2;
                    end
                end
            end
            EXEC: begin
                inst_valid = 1'b1;
                if (exu_done) state_nx = UPD;
            end
            UPD: begin
                pc_we    = 1'b1;
                state_nx = halt_req ? HALT : AR;
            end
            FAULT: begin
                fetch_fault = 1'b1;
                if (fault_ack) begin
                    cause_nx = 2'd0;
                    state_nx = AR;
                end
            end
            HALT: halted = 1'b1;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state       <= IDLE;
            cnt         <= '0;
            inst        <= '0;
            fault_cause <= '0;
        end else begin
            state       <= state_nx;
            cnt         <= cnt_nx;
            inst        <= inst_nx;
            fault_cause <= cause_nx;
        end
    end
endmodule

// File: tb/tb_ifu_fetch_ctrl.sv
// tb_ifu_fetch_ctrl: directed bench with a per-cycle reference model for ifu_fetch_ctrl
module tb_ifu_fetch_ctrl;
    localparam int DW  = 64;
    localparam int IW  = 32;
    localparam int TMO = 255;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic [DW-1:0] pc = 64'h8000_0000;
    logic [DW-1:0] imem_araddr;
    logic          imem_arvalid;
    logic          imem_arready = 1'b0;
    logic [IW-1:0] imem_rdata = '0;
    logic [1:0]    imem_rresp = 2'b00;
    logic          imem_rvalid = 1'b0;
    logic          imem_rready;
    logic [IW-1:0] inst;
    logic          inst_valid;
    logic          exu_done = 1'b0;
    logic          halt_req = 1'b0;
    logic          pc_we;
    logic          fetch_fault;
    logic [1:0]    fault_cause;
    logic          fault_ack = 1'b0;
    logic          halted;

    always #5 clk = ~clk;

    ifu_fetch_ctrl #(.DW(DW), .IW(IW), .TMO(TMO)) dut (
        .clk(clk), .rstn(rstn), .pc(pc),
        .imem_araddr(imem_araddr), .imem_arvalid(imem_arvalid), .imem_arready(imem_arready),
        .imem_rdata(imem_rdata), .imem_rresp(imem_rresp), .imem_rvalid(imem_rvalid),
        .imem_rready(imem_rready), .inst(inst), .inst_valid(inst_valid), .exu_done(exu_done),
        .halt_req(halt_req), .pc_we(pc_we), .fetch_fault(fetch_fault), .fault_cause(fault_cause),
        .fault_ack(fault_ack), .halted(halted)
    );

    int total = 0;
    int bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    // environment: memory and execute stage with configurable latencies
    int ar_dly = 0, r_dly = 0, e_dly = 0;
    bit r_never = 0, force_rv = 0, exu_noise = 0, ack_noise = 0, ack = 0;
    logic [1:0] resp_v = 2'b00;
    int ar_cnt = 0, r_cnt = 0, e_cnt = 0;

    function automatic logic [IW-1:0] rd_of(input logic [DW-1:0] a);
        return 32'h13 + {4'h0, a[17:2], 12'h000};
    endfunction

    task automatic drive();
        imem_arready = imem_arvalid && ar_cnt >= ar_dly;
        imem_rvalid  = force_rv || (imem_rready && !r_never && r_cnt >= r_dly);
        imem_rresp   = imem_rvalid ? resp_v : 2'b00;
        imem_rdata   = imem_rvalid ? rd_of(pc) : '0;
        exu_done     = inst_valid ? (e_cnt >= e_dly) : exu_noise;
        fault_ack    = ack || (ack_noise && !fetch_fault);
    endtask

    task automatic cycle();
        logic was_ar, was_r, was_e, was_we;
        was_ar = imem_arvalid;
        was_r  = imem_rready;
        was_e  = inst_valid;
        was_we = pc_we;
        @(posedge clk);
        #1;
        if (was_we) pc = pc + 64'd4;
        #1;
        ar_cnt = !imem_arvalid ? 0 : (was_ar ? ar_cnt + 1 : 0);
        r_cnt  = !imem_rready ? 0 : (was_r ? r_cnt + 1 : 0);
        e_cnt  = !inst_valid ? 0 : (was_e ? e_cnt + 1 : 0);
        drive();
    endtask

    function automatic logic sel(input int k);
        case (k)
            0: return imem_arvalid;
            1: return imem_rready;
            2: return inst_valid;
            3: return pc_we;
            4: return fetch_fault;
            default: return halted;
        endcase
    endfunction

    task automatic wait_until(input int k, input int budget, input string nm);
        int n = 0;
        while (!sel(k) && n < budget) begin
            n++;
            cycle();
        end
        chk(nm, sel(k), 1'b1);
    endtask

    task automatic count_while(input int k, input int budget, output int n);
        n = 0;
        while (sel(k) && n < budget) begin
            n++;
            cycle();
        end
    endtask

    task automatic rst_seq();
        rstn = 1'b0;
        drive();
        cycle();
        cycle();
        rstn = 1'b1;
        drive();
    endtask

    task automatic do_ack();
        ack = 1;
        drive();
        cycle();
        ack = 0;
        drive();
    endtask

    // reference model: tracks which part of the fetch loop is active, from the protocol rules
    bit live = 0;
    bit m_boot, m_req, m_wait, m_exec, m_upd, m_flt, m_hlt;
    logic [1:0] m_cause;
    logic [IW-1:0] m_inst;
    int mcyc = 0, hs_cyc = 0;

    always @(posedge clk) begin
        mcyc++;
        if (!rstn) begin
            live = 1;
            m_boot = 1;
            {m_req, m_wait, m_exec, m_upd, m_flt, m_hlt} = '0;
            m_cause = 2'd0;
            m_inst = '0;
        end else if (m_boot) begin
            m_boot = 0;
            if (halt_req) m_hlt = 1; else m_req = 1;
        end else if (m_req) begin
            if (pc[1:0] != 2'b00) begin
                m_req = 0; m_flt = 1; m_cause = 2'd3;
            end else if (imem_arready) begin
                m_req = 0; m_wait = 1; hs_cyc = mcyc;
            end
        end else if (m_wait) begin
            if (imem_rvalid) begin
                m_wait = 0;
                if (imem_rresp == 2'b00) begin
                    m_exec = 1; m_inst = imem_rdata;
                end else begin
                    m_flt = 1; m_cause = 2'd1;
                end
            end else if (mcyc - hs_cyc == TMO) begin
                m_wait = 0; m_flt = 1; m_cause = 2'd2;
            end
        end else if (m_exec) begin
            if (exu_done) begin m_exec = 0; m_upd = 1; end
        end else if (m_upd) begin
            m_upd = 0;
            if (halt_req) m_hlt = 1; else m_req = 1;
        end else if (m_flt) begin
            if (fault_ack) begin m_flt = 0; m_cause = 2'd0; m_req = 1; end
        end
    end

    bit p_hold = 0, p_rstn = 0;
    logic [DW-1:0] p_addr;

    always @(negedge clk) begin
        if (live) begin
            chk("arvalid", imem_arvalid, m_req && pc[1:0] == 2'b00);
            chk("araddr", imem_araddr, pc);
            chk("rready", imem_rready, m_wait);
            chk("inst_valid", inst_valid, m_exec);
            chk("inst", inst, m_inst);
            chk("pc_we", pc_we, m_upd);
            chk("fetch_fault", fetch_fault, m_flt);
            chk("fault_cause", fault_cause, m_cause);
            chk("halted", halted, m_hlt);
            chk("we_and_valid", pc_we & inst_valid, 1'b0);
            if (p_hold && p_rstn) begin
                chk("ar_hold", imem_arvalid, 1'b1);
                chk("ar_addr_hold", imem_araddr, p_addr);
            end
            p_hold = imem_arvalid && !imem_arready;
            p_addr = imem_araddr;
            p_rstn = rstn;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, a_cnt, w_cnt;
        logic [DW-1:0] a0;
        // zero-wait fetch loop timing
        rst_seq();
        cycle();
        chk("c1_arvalid", imem_arvalid, 1'b1);
        chk("c1_araddr", imem_araddr, 64'h8000_0000);
        cycle();
        chk("c2_rready", imem_rready, 1'b1);
        cycle();
        chk("c3_inst_valid", inst_valid, 1'b1);
        chk("c3_inst", inst, 64'h13);
        cycle();
        chk("c4_pc_we", pc_we, 1'b1);
        cycle();
        chk("c5_arvalid", imem_arvalid, 1'b1);
        chk("c5_araddr", imem_araddr, 64'h8000_0004);
        cycle();
        cycle();
        chk("c7_inst", inst, 64'h1013);
        // slow memory and execute, with stray exu_done/fault_ack outside their states
        ar_dly = 3; r_dly = 5; e_dly = 2; exu_noise = 1; ack_noise = 1;
        drive();
        wait_until(0, 10, "slow_ar_start");
        a0 = imem_araddr;
        count_while(0, 20, n); chk("slow_ar_cycles", n, 4);
        count_while(1, 20, n); chk("slow_r_cycles", n, 6);
        count_while(2, 20, n); chk("slow_exec_cycles", n, 3);
        count_while(3, 20, n); chk("slow_pc_we_cycles", n, 1);
        chk("slow_next_addr", imem_araddr, a0 + 64'd4);
        // bus error then retry at the same address
        ar_dly = 0; r_dly = 0; e_dly = 0; exu_noise = 0; ack_noise = 0; resp_v = 2'd2;
        drive();
        wait_until(4, 10, "buserr_fault");
        chk("buserr_cause", fault_cause, 2'd1);
        a0 = pc;
        repeat (3) cycle();
        chk("buserr_held", fetch_fault, 1'b1);
        resp_v = 2'd0;
        do_ack();
        chk("buserr_retry_arvalid", imem_arvalid, 1'b1);
        chk("buserr_retry_addr", imem_araddr, a0);
        // response timeout
        r_never = 1;
        drive();
        wait_until(1, 10, "tmo_r_start");
        count_while(1, 300, n);
        chk("tmo_r_cycles", n, TMO);
        chk("tmo_fault", fetch_fault, 1'b1);
        chk("tmo_cause", fault_cause, 2'd2);
        r_never = 0; r_dly = TMO - 1;
        do_ack();
        // rvalid on the last allowed cycle is accepted
        wait_until(1, 10, "race_r_start");
        count_while(1, 300, n);
        chk("race_r_cycles", n, TMO);
        chk("race_inst_valid", inst_valid, 1'b1);
        chk("race_no_fault", fetch_fault, 1'b0);
        r_dly = 0;
        drive();
        // misaligned pc never reaches the bus
        pc = 64'h8000_0002;
        rst_seq();
        a_cnt = 0;
        repeat (3) begin
            cycle();
            a_cnt += imem_arvalid;
        end
        chk("misal_no_arvalid", a_cnt, 0);
        chk("misal_fault", fetch_fault, 1'b1);
        chk("misal_cause", fault_cause, 2'd3);
        pc = 64'h8000_0100;
        do_ack();
        chk("misal_retry_addr", imem_araddr, 64'h8000_0100);
        chk("misal_retry_arvalid", imem_arvalid, 1'b1);
        wait_until(2, 10, "misal_exec");
        chk("misal_inst", inst, 64'h40013);
        // one-cycle reset in the middle of a read, with a late rvalid
        r_dly = 10;
        drive();
        wait_until(1, 10, "mid_r_start");
        cycle();
        cycle();
        rstn = 1'b0; force_rv = 1;
        drive();
        cycle();
        chk("rst_arvalid", imem_arvalid, 1'b0);
        chk("rst_rready", imem_rready, 1'b0);
        chk("rst_inst", inst, 64'h0);
        chk("rst_inst_valid", inst_valid, 1'b0);
        chk("rst_pc_we", pc_we, 1'b0);
        chk("rst_fault", {fetch_fault, fault_cause}, 3'b000);
        chk("rst_halted", halted, 1'b0);
        rstn = 1'b1;
        drive();
        cycle();
        chk("rst_restart_arvalid", imem_arvalid, 1'b1);
        force_rv = 0; r_dly = 0;
        drive();
        wait_until(3, 10, "rst_restart_pc_we");
        // halt raised during execute
        e_dly = 3;
        drive();
        wait_until(2, 10, "halt_exec");
        halt_req = 1'b1;
        a_cnt = 0; w_cnt = 0;
        repeat (20) begin
            cycle();
            a_cnt += imem_arvalid;
            w_cnt += pc_we;
        end
        chk("halt_pc_we_once", w_cnt, 1);
        chk("halt_no_arvalid", a_cnt, 0);
        chk("halt_halted", halted, 1'b1);
        // halt requested while leaving reset
        rst_seq();
        cycle();
        chk("idle_halt", halted, 1'b1);
        chk("idle_halt_no_arvalid", imem_arvalid, 1'b0);
        halt_req = 1'b0;
        drive();
        repeat (3) cycle();
        chk("idle_halt_stays", halted, 1'b1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
